// File: rtl/event_arbiter_pkg.sv
// Shared types and helpers for the event arbiter.
// Optional drop counter is enabled by EVENT_ARB_DROP_CNT_EN.
package event_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_OFFER
  } state_t;

  localparam int DROP_CNT_W = 8;

  // Next index in round-robin order, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/event_arbiter_if.sv
// Event inputs plus the valid/ready offer bus of the event arbiter.
// o_Drop_Cnt is present only when EVENT_ARB_DROP_CNT_EN is defined.
interface event_arbiter_if #(
  parameter int NUM_CH = 4
);
  import event_arbiter_pkg::*;

  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] i_Data;
  logic [NUM_CH-1:0] i_Mask;
  logic              i_Ready;
  logic              o_Valid;
  logic [CH_W-1:0]   o_Ch_Id;
  logic [NUM_CH-1:0] o_Pending;
`ifdef EVENT_ARB_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] o_Drop_Cnt;

  modport slave  (input i_Data, i_Mask, i_Ready,
                  output o_Valid, o_Ch_Id, o_Pending, o_Drop_Cnt);
  modport master (output i_Data, i_Mask, i_Ready,
                  input o_Valid, o_Ch_Id, o_Pending, o_Drop_Cnt);
`else
  modport slave  (input i_Data, i_Mask, i_Ready,
                  output o_Valid, o_Ch_Id, o_Pending);
  modport master (output i_Data, i_Mask, i_Ready,
                  input o_Valid, o_Ch_Id, o_Pending);
`endif

endinterface

// File: rtl/event_arbiter_channel.sv
// One event channel: synchronizer, rising-edge detect, mask gating,
// pending latch and a one-cycle drop pulse for merged edges.
module event_arbiter_channel #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic data,
  input  logic mask,
  input  logic clear,
  output logic pending,
  output logic drop
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   pending_reg;
  logic                   pending_next;
  logic                   edge_det;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg    <= '0;
      prev_reg    <= 1'b0;
      pending_reg <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[SYNC_STAGES-2:0], data};
      prev_reg    <= sync_reg[SYNC_STAGES-1];
      pending_reg <= pending_next;
    end
  end

  // A new edge wins over a same-cycle clear, so it is kept rather than dropped.
  always_comb begin
    edge_det     = sync_reg[SYNC_STAGES-1] & ~prev_reg;
    pending_next = (pending_reg & ~clear) | (edge_det & mask);
    drop         = edge_det & mask & pending_reg & ~clear;
  end

  assign pending = pending_reg;

endmodule

// File: rtl/event_arbiter.sv
// Round-robin event arbiter: per-channel edge latches feeding a two-state
// offer FSM. Drop counter is built only with EVENT_ARB_DROP_CNT_EN.
module event_arbiter
  import event_arbiter_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            reset,
  event_arbiter_if.slave bus
);

  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] drop;
  logic [NUM_CH-1:0] clear;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      event_arbiter_channel #(.SYNC_STAGES(SYNC_STAGES)) u_ch (
        .clk     (clk),
        .reset   (reset),
        .data    (bus.i_Data[gi]),
        .mask    (bus.i_Mask[gi]),
        .clear   (clear[gi]),
        .pending (pending[gi]),
        .drop    (drop[gi])
      );
    end
  endgenerate

  state_t          state_reg, state_next;
  logic [CH_W-1:0] ch_id_reg, ch_id_next;
  logic [CH_W-1:0] last_grant_reg, last_grant_next;
  logic            sel_found;
  logic [CH_W-1:0] sel_idx;

  always_comb begin : rr_search
    logic [CH_W-1:0] idx;
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = CH_W'(rr_next(int'(last_grant_reg), NUM_CH));
    for (int i = 0; i < NUM_CH; i++) begin
      if (!sel_found && pending[idx]) begin
        sel_found = 1'b1;
        sel_idx   = idx;
      end
      idx = CH_W'(rr_next(int'(idx), NUM_CH));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      ch_id_reg      <= '0;
      last_grant_reg <= CH_W'(NUM_CH - 1);
    end else begin
      state_reg      <= state_next;
      ch_id_reg      <= ch_id_next;
      last_grant_reg <= last_grant_next;
    end
  end

  always_comb begin
    logic load;
    state_next      = state_reg;
    ch_id_next      = ch_id_reg;
    last_grant_next = last_grant_reg;
    clear           = '0;
    load            = 1'b0;
    case (state_reg)
      ST_IDLE:  load = sel_found;
      ST_OFFER: begin
        if (bus.i_Ready) begin
          if (sel_found) load = 1'b1;
          else           state_next = ST_IDLE;
        end
      end
      default:  state_next = ST_IDLE;
    endcase
    // Selection pulls the bit out of pending as it becomes the offer.
    if (load) begin
      state_next      = ST_OFFER;
      ch_id_next      = sel_idx;
      last_grant_next = sel_idx;
      clear[sel_idx]  = 1'b1;
    end
  end

  assign bus.o_Valid   = (state_reg == ST_OFFER);
  assign bus.o_Ch_Id   = ch_id_reg;
  assign bus.o_Pending = pending;

`ifdef EVENT_ARB_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_reg, drop_cnt_next;

  always_comb begin
    int sum;
    sum = int'(drop_cnt_reg);
    for (int i = 0; i < NUM_CH; i++) begin
      sum = sum + (drop[i] ? 1 : 0);
    end
    drop_cnt_next = (sum > (1 << DROP_CNT_W) - 1) ? '1 : DROP_CNT_W'(sum);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_cnt_reg <= '0;
    else       drop_cnt_reg <= drop_cnt_next;
  end

  assign bus.o_Drop_Cnt = drop_cnt_reg;
`else
  logic drop_unused;
  assign drop_unused = |drop;
`endif

endmodule

// File: tb/tb_event_arbiter.sv
// Bench for event_arbiter: directed vector table, hand sequences and random
// traffic against a cycle model. Drop checks follow EVENT_ARB_DROP_CNT_EN.
module tb_event_arbiter;
  import event_arbiter_pkg::*;

  localparam int NUM_CH = 4;
  localparam int S      = 2;

  logic clk = 1'b0;
  logic reset;

  event_arbiter_if #(.NUM_CH(NUM_CH)) bus ();

  event_arbiter #(.NUM_CH(NUM_CH), .SYNC_STAGES(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: samples pass through an S-deep delay line, then the
  // scheduler rules are applied once per clock edge.
  logic [NUM_CH-1:0] m_hist [0:S];
  logic [NUM_CH-1:0] m_pend;
  bit                m_valid;
  int                m_id, m_last, m_drop;

  task automatic model_reset();
    for (int j = 0; j <= S; j++) m_hist[j] = '0;
    m_pend  = '0;
    m_valid = 0;
    m_id    = 0;
    m_last  = NUM_CH - 1;
    m_drop  = 0;
  endtask

  task automatic model_step();
    logic [NUM_CH-1:0] ev, set, clr;
    bit found;
    int idx;
    ev  = m_hist[S-1] & ~m_hist[S];
    set = ev & bus.i_Mask;
    clr = '0;
    if (!m_valid || bus.i_Ready) begin
      found = 0;
      for (int k = 1; k <= NUM_CH; k++) begin
        idx = (m_last + k) % NUM_CH;
        if (!found && m_pend[idx]) begin
          found = 1;
          m_id  = idx;
        end
      end
      if (found) begin
        m_valid    = 1;
        m_last     = m_id;
        clr[m_id]  = 1'b1;
      end else begin
        m_valid = 0;
      end
    end
    for (int c = 0; c < NUM_CH; c++)
      if (set[c] && m_pend[c] && !clr[c]) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
    m_pend = (m_pend & ~clr) | set;
    for (int j = S; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = bus.i_Data;
  endtask

  task automatic check_model();
    check("mdl_valid", int'(bus.o_Valid), int'(m_valid));
    if (m_valid) check("mdl_ch_id", int'(bus.o_Ch_Id), m_id);
    check("mdl_pending", int'(bus.o_Pending), int'(m_pend));
`ifdef EVENT_ARB_DROP_CNT_EN
    check("mdl_drop_cnt", int'(bus.o_Drop_Cnt), m_drop);
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    logic [NUM_CH-1:0] data;
    logic [NUM_CH-1:0] mask;
    logic              ready;
    logic              v;
    int                id;
    logic [NUM_CH-1:0] pend;
  } vec_t;

  vec_t tbl [19];
  int   cnt;

  initial begin
    tbl[0]  = '{4'h0, 4'hF, 1'b1, 1'b0, 0, 4'h0};
    tbl[1]  = '{4'hF, 4'hF, 1'b1, 1'b0, 0, 4'h0};
    tbl[2]  = '{4'hF, 4'hF, 1'b1, 1'b0, 0, 4'h0};
    tbl[3]  = '{4'hF, 4'hF, 1'b1, 1'b0, 0, 4'hF};
    tbl[4]  = '{4'hF, 4'hF, 1'b1, 1'b1, 0, 4'hE};
    tbl[5]  = '{4'hF, 4'hF, 1'b1, 1'b1, 1, 4'hC};
    tbl[6]  = '{4'h0, 4'hF, 1'b1, 1'b1, 2, 4'h8};
    tbl[7]  = '{4'h0, 4'hF, 1'b1, 1'b1, 3, 4'h0};
    tbl[8]  = '{4'h0, 4'hF, 1'b1, 1'b0, 0, 4'h0};
    tbl[9]  = '{4'h4, 4'hF, 1'b1, 1'b0, 0, 4'h0};
    tbl[10] = '{4'h0, 4'hF, 1'b1, 1'b0, 0, 4'h0};
    tbl[11] = '{4'h0, 4'hF, 1'b1, 1'b0, 0, 4'h4};
    tbl[12] = '{4'h0, 4'hF, 1'b1, 1'b1, 2, 4'h0};
    tbl[13] = '{4'h0, 4'hF, 1'b1, 1'b0, 0, 4'h0};
    tbl[14] = '{4'h4, 4'hB, 1'b1, 1'b0, 0, 4'h0};
    tbl[15] = '{4'h0, 4'hB, 1'b1, 1'b0, 0, 4'h0};
    tbl[16] = '{4'h0, 4'hB, 1'b1, 1'b0, 0, 4'h0};
    tbl[17] = '{4'h0, 4'hF, 1'b1, 1'b0, 0, 4'h0};
    tbl[18] = '{4'h0, 4'hF, 1'b1, 1'b0, 0, 4'h0};

    reset       = 1'b1;
    bus.i_Data  = '0;
    bus.i_Mask  = '1;
    bus.i_Ready = 1'b1;
    #16;
    check("rst_valid", int'(bus.o_Valid), 0);
    check("rst_ch_id", int'(bus.o_Ch_Id), 0);
    check("rst_pending", int'(bus.o_Pending), 0);
`ifdef EVENT_ARB_DROP_CNT_EN
    check("rst_drop_cnt", int'(bus.o_Drop_Cnt), 0);
`endif
    model_reset();
    reset = 1'b0;

    // Directed vectors: burst on all channels, single ch2 pulse, masked ch2 pulse.
    for (int i = 0; i < 19; i++) begin
      bus.i_Data  = tbl[i].data;
      bus.i_Mask  = tbl[i].mask;
      bus.i_Ready = tbl[i].ready;
      tick();
      check($sformatf("tbl%0d_valid", i), int'(bus.o_Valid), int'(tbl[i].v));
      if (tbl[i].v) check($sformatf("tbl%0d_ch_id", i), int'(bus.o_Ch_Id), tbl[i].id);
      check($sformatf("tbl%0d_pending", i), int'(bus.o_Pending), int'(tbl[i].pend));
    end

    // Offer held with i_Ready low; ch3 arrives meanwhile.
    bus.i_Ready = 1'b0;
    bus.i_Data  = 4'h2; tick();
    bus.i_Data  = 4'h0; tick(); tick(); tick();
    check("hold_start_valid", int'(bus.o_Valid), 1);
    check("hold_start_id", int'(bus.o_Ch_Id), 1);
    for (int i = 0; i < 10; i++) begin
      bus.i_Data = (i == 1) ? 4'h8 : 4'h0;
      tick();
      check("hold_id", int'(bus.o_Ch_Id), 1);
      check("hold_valid", int'(bus.o_Valid), 1);
    end
    check("hold_pend3", int'(bus.o_Pending[3]), 1);
    bus.i_Ready = 1'b1;
    tick();
    check("release_id", int'(bus.o_Ch_Id), 3);
    check("release_valid", int'(bus.o_Valid), 1);
    tick();
    check("release_idle", int'(bus.o_Valid), 0);

    // Two ch0 edges while ch0 waits behind a held ch1 offer.
    bus.i_Ready = 1'b0;
    bus.i_Data  = 4'h2; tick();
    bus.i_Data  = 4'h0; tick(); tick(); tick();
    bus.i_Data  = 4'h1; tick();
    bus.i_Data  = 4'h0; tick();
    bus.i_Data  = 4'h1; tick();
    bus.i_Data  = 4'h0; tick(); tick(); tick();
    check("merge_pend0", int'(bus.o_Pending[0]), 1);
    check("merge_offer_id", int'(bus.o_Ch_Id), 1);
`ifdef EVENT_ARB_DROP_CNT_EN
    check("merge_drop_cnt", int'(bus.o_Drop_Cnt), 1);
`endif
    bus.i_Ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.o_Valid && bus.o_Ch_Id == 0) cnt++;
    end
    check("merge_ch0_events", cnt, 1);

    // i_Data[1] high through reset release yields exactly one event.
    reset       = 1'b1;
    bus.i_Data  = 4'h2;
    #1;
    check("rst2_valid", int'(bus.o_Valid), 0);
    model_reset();
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.o_Valid && bus.o_Ch_Id == 1) cnt++;
    end
    check("held_high_events", cnt, 1);
    bus.i_Data = 4'h0;
    tick();

    // Reset during an offer with ch3 pending.
    bus.i_Ready = 1'b0;
    bus.i_Data  = 4'h4; tick();
    bus.i_Data  = 4'h0; tick(); tick(); tick();
    bus.i_Data  = 4'h8; tick();
    bus.i_Data  = 4'h0; tick(); tick();
    check("pre_rst_valid", int'(bus.o_Valid), 1);
    check("pre_rst_pend", int'(bus.o_Pending), 8);
    reset = 1'b1;
    #1;
    check("async_rst_valid", int'(bus.o_Valid), 0);
    check("async_rst_pending", int'(bus.o_Pending), 0);
    model_reset();
    #1;
    reset = 1'b0;

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      bus.i_Data  = bus.i_Data ^ NUM_CH'($urandom_range(0, 15) & $urandom_range(0, 15));
      bus.i_Mask  = ($urandom_range(0, 7) == 0) ? NUM_CH'($urandom_range(0, 15)) : '1;
      bus.i_Ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Stalled consumer with toggling inputs drives the drop count to saturation.
    bus.i_Mask  = '1;
    bus.i_Ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      bus.i_Data = ~bus.i_Data;
      tick();
    end
`ifdef EVENT_ARB_DROP_CNT_EN
    check("drop_saturated", int'(bus.o_Drop_Cnt), 255);
`endif
    bus.i_Ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.i_Data = '0;
      tick();
    end
    check("drain_idle", int'(bus.o_Valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/event_arbiter.md
# event_arbiter

Multi-channel event controller that sits in front of a downstream consumer shared by several asynchronous event sources. Each channel synchronizes its input, detects rising edges and latches them as pending. A round-robin scheduler then presents pending events one at a time over a valid/ready handshake, tagging each with its channel ID. It replaces per-source event detectors when one consumer must serve all of them.

## Interface
- NUM_CH, 4, number of event channels (2..16)
- SYNC_STAGES, 2, synchronizer depth per channel (2..3)
- CH_W, $clog2(NUM_CH), channel ID width (derived, not overridable)

- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- i_Data  in  NUM_CH  asynchronous event inputs, one bit per channel
- i_Mask  in  NUM_CH  1 = channel enabled; 0 = channel's edges discarded
- o_Valid  out  1  event presented on o_Ch_Id
- i_Ready  in  1  consumer accepts presented event
- o_Ch_Id  out  CH_W  channel ID of presented event
- o_Pending  out  NUM_CH  current pending bits (status)
- o_Drop_Cnt  out  8  dropped-event count (only with EVENT_ARB_DROP_CNT_EN)

## Operation
- Per channel: SYNC_STAGES-flop synchronizer, then prev flop; edge = sync_out & ~prev.
- Edge with i_Mask[c]=1 and pending[c]=0: sets pending[c].
- Edge with i_Mask[c]=1 and pending[c]=1: merged and dropped, counted when the macro is on.
- Edge with i_Mask[c]=0: discarded, never counted.
- FSM states IDLE and OFFER.
  - IDLE: o_Valid=0. If any pending bit is set: select a channel, load o_Ch_Id, clear its pending bit, go to OFFER.
  - OFFER: o_Valid=1. o_Ch_Id is held stable until i_Ready=1.
  - On handshake with another pending bit set: load the next selection in the same cycle and stay in OFFER. This is back-to-back, one event per cycle.
  - On handshake with nothing pending: go to IDLE.
- Round-robin selection: search starts at last_grant+1 and wraps modulo NUM_CH. last_grant updates on every selection.
- Simultaneous clear and set: if a new edge arrives on channel c in the cycle its pending bit is cleared by selection, pending[c] stays 1.
- Deasserting i_Mask[c] does not clear pending[c] and does not withdraw an offered event. Mask gates new edges only.
- Reset values:
  - synchronizers, prev, pending, o_Valid, o_Ch_Id, o_Drop_Cnt: 0
  - last_grant: NUM_CH-1, so channel 0 has priority first
  - state: IDLE
- An input already high at reset release produces one event, because prev resets to 0.
- Reset asserted mid-offer: o_Valid drops immediately (asynchronous) and the event is lost.

## Timing
- Input rise sampled at edge k: pending set at edge k+SYNC_STAGES, o_Valid high after edge k+SYNC_STAGES+1 when the FSM is IDLE.
- Handshake completes at the rising edge where o_Valid=1 and i_Ready=1.
- o_Valid, o_Ch_Id and o_Pending are registered with no combinational path from inputs. i_Ready affects the next state only.
- Sustained throughput is 1 event/cycle with i_Ready held high.
- Minimum input pulse width for guaranteed detection is 1 clk period plus setup/hold.

## Configuration
- EVENT_ARB_DROP_CNT_EN defined:
  - o_Drop_Cnt exists.
  - Increments by the number of channels dropping in that cycle, saturating at 255.
  - Cleared only by reset.
- Undefined: the o_Drop_Cnt port and its counter are absent. Drops remain silent.

## Structure
- Package event_arbiter_pkg holds:
  - state enum (ST_IDLE, ST_OFFER)
  - DROP_CNT_W = 8
  - round-robin next-index function
- Sub-module event_arbiter_channel contains the synchronizer, edge detect, mask gating, pending bit and drop pulse output. It is instantiated NUM_CH times.
- The top level contains the scheduler FSM, round-robin pointer and drop counter.

## Test plan
- Reset, i_Ready=1, single pulse on ch2: o_Valid=1 with o_Ch_Id=2 for exactly 1 cycle, 3 edges after the sample edge (SYNC_STAGES=2). o_Pending returns to 0.
- ch0..ch3 rise in the same cycle, i_Ready=1: IDs 0,1,2,3 on 4 consecutive cycles, then o_Valid=0.
- i_Ready=0 while ch1 is offered: o_Ch_Id holds at 1 for 10 cycles. A ch3 edge meanwhile sets o_Pending[3]. Releasing i_Ready gives 1 then 3.
- Two ch0 edges while ch0 is pending (i_Ready=0): only one ch0 event is delivered. o_Drop_Cnt=1 with the macro on.
- i_Mask[2]=0 during a ch2 pulse: no event and no drop count. Reasserting i_Mask does not replay the pulse.
- i_Data[1] held high through reset release: exactly one ch1 event. Reset asserted while o_Valid=1: o_Valid=0 immediately and all pending bits are cleared.
